mem_arbiter: RTL

Arbiter for the single main-memory port, shared between the pipeline's stage-3 memory access and a DMA/debug requester (program loader, test harness). It sits between `reg_pipe_stage_b` outputs and `mem_main`. It drives the memory address, write enable and write data from the granted requester. It raises `cpu_stall` when stage 3 loses arbitration. The grant policy is CPU-priority with DMA bursts and a starvation bound.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_sat_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory port arbiter.
//   arb_state_e : arbiter FSM state (CPU-priority mode or inside a DMA burst)
//   arb_gnt_e   : which requester owns the memory port in the current cycle
//   DATA_W / ADDR_W / PERF_W : datapath, address and perf-counter widths
package mem_arbiter_pkg;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DMA = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } arb_gnt_e;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int PERF_W = 16;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// sat_counter: up-counter that saturates at MAX, with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   inc      : count up by one unless already at MAX
//   clr      : clear to zero (wins over inc)
//   count    : current value, W bits
module sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between pipeline stage 3
// (CPU) and a DMA/debug requester. CPU has priority; DMA may hold the port
// for a burst of up to MAX_BURST beats; a DMA beat refused STARVE_LIMIT
// times is forced through. halt_sys masks CPU requests so DMA owns the port.
//
// Handshake: the DMA side is valid/ready. A beat is presented with dma_valid
// and transfers in the cycle dma_ready is high; dma_valid/addr/wdata/wr/last
// must stay stable until then. Read data of an accepted read beat comes back
// on dma_rdata with a one-cycle dma_rvalid pulse in the following cycle.
// The CPU side has no ready: it sees cpu_stall and holds its request.
//
// Ports:
//   clk, rst                                 clock, async active-high reset
//   halt_sys                                 CPU halted, CPU requests ignored
//   cpu_req/cpu_wr/cpu_addr/cpu_wdata        stage-3 access
//   cpu_rdata, cpu_stall                     read data / stall to stage 3
//   dma_valid/dma_wr/dma_last/dma_addr/dma_wdata   DMA beat
//   dma_ready, dma_rdata, dma_rvalid         DMA accept / registered read data
//   mem_addr/mem_we/mem_wdata, mem_rdata     memory port (combinational read)
//   perf_cpu_stall, perf_dma_beats           performance counters
//   arb_state                                FSM state (1 = inside DMA burst)
//
// Build option: define ARB_PERF_EN to implement the saturating perf counters;
// otherwise both perf outputs are tied to zero.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_valid,
  input  logic        dma_wr,
  input  logic        dma_last,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ready,
  output logic [15:0] dma_rdata,
  output logic        dma_rvalid,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] perf_cpu_stall,
  output logic [15:0] perf_dma_beats,
  output logic        arb_state
);

  // A limit of 0 would give a zero-width counter; keep at least one bit.
  localparam int WAIT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int BURST_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  arb_state_e         state, next_state;
  arb_gnt_e           gnt;
  logic               creq;
  logic               cpu_gnt, dma_gnt;
  logic               wait_ok;
  logic               burst_end;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [BURST_W-1:0] burst_cnt;

  assign creq    = cpu_req & ~halt_sys;
  assign wait_ok = (wait_cnt < WAIT_W'(STARVE_LIMIT));
  // burst_cnt counts beats already granted in this burst, so the beat
  // granted now is number burst_cnt+1.
  assign burst_end = (burst_cnt >= BURST_W'(MAX_BURST - 1));

  always_comb begin
    gnt        = GNT_NONE;
    next_state = state;
    unique case (state)
      ARB_CPU: begin
        // CPU also wins when nothing is waiting on the DMA side, otherwise a
        // saturated wait_cnt with an idle DMA would stall the CPU forever.
        if (creq && (wait_ok || !dma_valid)) begin
          gnt = GNT_CPU;
        end else if (dma_valid) begin
          gnt = GNT_DMA;
          if (!dma_last && (MAX_BURST > 1)) next_state = ARB_DMA;
        end
      end
      ARB_DMA: begin
        if (dma_valid) begin
          gnt = GNT_DMA;
          if (dma_last || burst_end) next_state = ARB_CPU;
        end else if (creq) begin
          gnt = GNT_CPU;  // bubble in the burst: lend the port to the CPU
        end
      end
      default: begin
        next_state = ARB_CPU;
      end
    endcase
  end

  assign cpu_gnt   = (gnt == GNT_CPU);
  assign dma_gnt   = (gnt == GNT_DMA);
  assign cpu_stall = creq & ~cpu_gnt;
  assign dma_ready = dma_gnt;
  assign cpu_rdata = mem_rdata;
  assign arb_state = (state == ARB_DMA);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_wr;
    end else if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_wr;
    end
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_CPU;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
    end else begin
      dma_rvalid <= dma_gnt & ~dma_wr;
      if (dma_gnt && !dma_wr) dma_rdata <= mem_rdata;
    end
  end

  sat_counter #(.W(WAIT_W), .MAX(STARVE_LIMIT)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dma_valid & ~dma_gnt),
    .clr   (dma_gnt),
    .count (wait_cnt)
  );

  // Counts every DMA grant; cleared on the beat that closes the burst, so it
  // reads 1 after the opening beat and is back at 0 outside a burst.
  sat_counter #(.W(BURST_W), .MAX(MAX_BURST)) u_burst_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dma_gnt),
    .clr   (dma_gnt & (next_state == ARB_CPU)),
    .count (burst_cnt)
  );

`ifdef ARB_PERF_EN
  sat_counter #(.W(PERF_W), .MAX(16'hFFFF)) u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (cpu_stall),
    .clr   (1'b0),
    .count (perf_cpu_stall)
  );

  sat_counter #(.W(PERF_W), .MAX(16'hFFFF)) u_perf_beats (
    .clk   (clk),
    .rst   (rst),
    .inc   (dma_ready),
    .clr   (1'b0),
    .count (perf_dma_beats)
  );
`else
  assign perf_cpu_stall = '0;
  assign perf_dma_beats = '0;
`endif

endmodule
